// File: rtl/fft_out_reorder_pkg.sv
// rtl/fft_out_reorder_pkg.sv - shared constants, read FSM states and bit-reverse helper
package fft_out_reorder_pkg;

    localparam int N_FFT = 32;
    localparam int LOG2N = 5;
    localparam int HALF  = 16;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // 5-bit bit reverse: maps the bin index to its position in the pipeline's output order
    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - lane-pair input and natural-order output bundle
interface fft_out_reorder_if #(parameter int WIDTH = 9);

    logic             in_valid;
    logic             in_start;
    logic [WIDTH-1:0] in_up_re;
    logic [WIDTH-1:0] in_up_im;
    logic [WIDTH-1:0] in_l_re;
    logic [WIDTH-1:0] in_l_im;

    logic             out_ready;
    logic             out_valid;
    logic [3:0]       out_idx;
    logic             out_last;
    logic [WIDTH-1:0] out0_re;
    logic [WIDTH-1:0] out0_im;
    logic [WIDTH-1:0] out1_re;
    logic [WIDTH-1:0] out1_im;
    logic             overflow;

    modport master (
        output in_valid, in_start, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
        input  out_valid, out_idx, out_last, out0_re, out0_im, out1_re, out1_im, overflow
    );

    modport slave (
        input  in_valid, in_start, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
        output out_valid, out_idx, out_last, out0_re, out0_im, out1_re, out1_im, overflow
    );

endinterface

// File: rtl/fft_out_reorder_bank.sv
// rtl/fft_out_reorder_bank.sv - ping-pong register bank, two write and two read ports
module fft_pingpong_bank
    import fft_out_reorder_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               we,
    input  logic               wbank,
    input  logic [LOG2N-1:0]   waddr_up,
    input  logic [LOG2N-1:0]   waddr_lo,
    input  logic [2*WIDTH-1:0] wdata_up,
    input  logic [2*WIDTH-1:0] wdata_lo,
    input  logic               rbank,
    input  logic [LOG2N-1:0]   raddr0,
    input  logic [LOG2N-1:0]   raddr1,
    output logic [2*WIDTH-1:0] rdata0,
    output logic [2*WIDTH-1:0] rdata1
);

    // each word packs {re, im}; contents are don't-care until written
    logic [2*WIDTH-1:0] mem [2][N_FFT];

    // both lanes of a pair land in the same bank, always at distinct addresses
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbank][waddr_up] <= wdata_up;
            mem[wbank][waddr_lo] <= wdata_lo;
        end
    end

    assign rdata0 = mem[rbank][raddr0];
    assign rdata1 = mem[rbank][raddr1];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - bit-reversed lane pairs in, natural-order bin pairs out
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_out_reorder_if.slave   bus
);

    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wbank;
    logic               rbank;
    logic [3:0]         wcnt;
    logic               ovf_q;
    rd_state_t          state;
    rd_state_t          state_nxt;

    logic               out_valid_q;
    logic [3:0]         rcnt;
    logic               out_last_q;
    logic [WIDTH-1:0]   o0_re, o0_im, o1_re, o1_im;

    logic               xfer;
    logic               xfer_last;
    logic               wr_free;
    logic               wr_blocked;
    logic               wr_en;
    logic               wr_done;
    logic [3:0]         wj;
    logic [LOG2N-1:0]   wa_up;
    logic [LOG2N-1:0]   wa_lo;

    logic               load;
    logic               drop_valid;
    logic               ld_bank;
    logic [3:0]         ld_pair;
    logic [2*WIDTH-1:0] rdata0;
    logic [2*WIDTH-1:0] rdata1;

    // write-side decode; a bank freed this edge counts as free for the incoming pair
    always_comb begin
        xfer       = (state == RD_STREAM) && out_valid_q && bus.out_ready;
        xfer_last  = xfer && (rcnt == 4'd15);
        wr_free    = xfer_last && (rbank == wbank);
        wr_blocked = full[wbank] && !wr_free;
        wr_en      = bus.in_valid && !wr_blocked;
        wj         = bus.in_start ? 4'd0 : wcnt;
        wr_done    = wr_en && (wj == 4'd15);
        wa_up      = bitrev5({wj, 1'b0});
        wa_lo      = wa_up + LOG2N'(HALF);
    end

    // full flags: release on the last output transfer, then set on a completed frame
    always_comb begin
        full_nxt = full;
        if (xfer_last) begin
            full_nxt[rbank] = 1'b0;
        end
        if (wr_done) begin
            full_nxt[wbank] = 1'b1;
        end
    end

    // write bank, frame counter, full flags and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 2'b00;
            wbank <= 1'b0;
            wcnt  <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            full <= full_nxt;
            if (bus.in_valid && wr_blocked) begin
                ovf_q <= 1'b1;
            end
            if (wr_en) begin
                if (wr_done) begin
                    wbank <= ~wbank;
                    wcnt  <= 4'd0;
                end else begin
                    wcnt  <= wj + 4'd1;
                end
            end
        end
    end

    // read FSM next state and output-register load selection
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        drop_valid = 1'b0;
        ld_bank    = rbank;
        ld_pair    = rcnt;
        case (state)
            RD_IDLE: begin
                if (full[rbank]) begin
                    state_nxt = RD_STREAM;
                    load      = 1'b1;
                    ld_pair   = 4'd0;
                end
            end
            RD_STREAM: begin
                if (xfer) begin
                    if (rcnt != 4'd15) begin
                        load    = 1'b1;
                        ld_pair = rcnt + 4'd1;
                    end else if (full[~rbank]) begin
                        load    = 1'b1;
                        ld_bank = ~rbank;
                        ld_pair = 4'd0;
                    end else begin
                        state_nxt  = RD_IDLE;
                        drop_valid = 1'b1;
                    end
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // read bank pointer and output register; holds everything when nothing is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank       <= 1'b0;
            out_valid_q <= 1'b0;
            rcnt        <= 4'd0;
            out_last_q  <= 1'b0;
            o0_re       <= '0;
            o0_im       <= '0;
            o1_re       <= '0;
            o1_im       <= '0;
        end else begin
            if (xfer_last) begin
                rbank <= ~rbank;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                rcnt        <= ld_pair;
                out_last_q  <= (ld_pair == 4'd15);
                o0_re       <= rdata0[2*WIDTH-1:WIDTH];
                o0_im       <= rdata0[WIDTH-1:0];
                o1_re       <= rdata1[2*WIDTH-1:WIDTH];
                o1_im       <= rdata1[WIDTH-1:0];
            end else if (drop_valid) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    fft_pingpong_bank #(.WIDTH(WIDTH)) u_bank (
        .clk      (clk),
        .we       (wr_en),
        .wbank    (wbank),
        .waddr_up (wa_up),
        .waddr_lo (wa_lo),
        .wdata_up ({bus.in_up_re, bus.in_up_im}),
        .wdata_lo ({bus.in_l_re, bus.in_l_im}),
        .rbank    (ld_bank),
        .raddr0   ({ld_pair, 1'b0}),
        .raddr1   ({ld_pair, 1'b1}),
        .rdata0   (rdata0),
        .rdata1   (rdata1)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = rcnt;
    assign bus.out_last  = out_last_q;
    assign bus.out0_re   = o0_re;
    assign bus.out0_im   = o0_im;
    assign bus.out1_re   = o1_re;
    assign bus.out1_im   = o1_im;
    assign bus.overflow  = ovf_q;

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output end of the 32-point radix-2 MDC FFT pipeline.
- Accepts the final stage's two parallel lanes (upper/lower), delivered in bit-reversed order.
- Buffers each frame in a ping-pong register bank.
- Re-emits the frame in natural order as two samples per cycle (even/odd bins) with a valid/ready handshake toward downstream.

Parameters:
- WIDTH, 9, bit width of each real/imag component (signed two's complement).
- N, 32, FFT points per frame; fixed at 32 for this block.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input lane pair valid this cycle.
- in_start  in  1  marks the first pair (j=0) of a frame; qualified by in_valid.
- in_up_re  in  WIDTH  upper lane real, signed.
- in_up_im  in  WIDTH  upper lane imag, signed.
- in_l_re  in  WIDTH  lower lane real, signed.
- in_l_im  in  WIDTH  lower lane imag, signed.
- out_ready  in  1  downstream accepts the output pair.
- out_valid  out  1  output pair valid.
- out_idx  out  4  pair index i (0..15); pair carries bins 2i and 2i+1.
- out_last  out  1  high with i=15.
- out0_re, out0_im  out  WIDTH each  bin X[2i].
- out1_re, out1_im  out  WIDTH each  bin X[2i+1].
- overflow  out  1  sticky: an input pair was dropped.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; both banks empty; write bank=0, read bank=0, wcnt=0, rcnt=0. Stored data need not be cleared.
- Input order (decided): pair j (0..15) carries upper=X[br5(2j)], lower=X[br5(2j)+16], where br5 is the 5-bit bit reverse.
- Write side:
  - On in_valid, write upper to address br5(2j) and lower to br5(2j)+16 of the write bank, j=wcnt.
  - in_valid with in_start forces j=0 and abandons any partial frame; the bank is not marked full.
  - in_valid without in_start while wcnt=0 and no frame is in progress: pair is written as j=0 (free-running framing).
  - On the 16th write (j=15), mark the bank full, toggle the write bank, and set wcnt=0.
- Overflow: in_valid while the current write bank is still full drops the pair, sets overflow (cleared only by reset), and leaves wcnt unchanged.
- Read side:
  - Read FSM states: IDLE, STREAM.
  - IDLE -> STREAM when the read bank is full. The output register loads pair i=0 on that edge; out_valid rises the cycle after the edge that wrote j=15. Latency is 1 cycle from frame completion.
  - In STREAM, a transfer occurs when out_valid && out_ready; the output register then loads i+1.
  - Without a transfer, all outputs hold stable.
  - On the transfer with i=15: mark the read bank empty and toggle the read bank. If the other bank is already full, load its i=0 on the same edge, giving back-to-back frames with no bubble. Otherwise, deassert out_valid and go to IDLE.
- Simultaneous events: a bank filling and a bank emptying on the same edge are both honoured. A write into bank b on the same edge that bank b is freed is accepted (free-before-write priority).
- Throughput: 16 input pairs per frame against 16 output pairs per frame, so continuous streaming never overflows when out_ready=1.
- Arithmetic: pure data movement, no width change or rounding.
- Reset mid-operation: abandons all frames, returns to the reset state.

Decomposition:
- Shared fft package: constants N_FFT=32, LOG2N=5, HALF=16; a bitrev5 function.
- Natural sub-module: fft_pingpong_bank (2×32×2×WIDTH register array; two write ports at the write bank, two read ports at the read bank).
- Control (wcnt, full flags, read FSM) stays in the top.

Test Plan:
- Single frame, X[k] has re=k, im=-k, fed as j=0..15 (j=1: up_re=8, l_re=24), out_ready=1 -> out_valid one cycle after j=15. Pair i has out0_re=2i, out1_re=2i+1, imag values negated. out_last at i=15; overflow=0.
- Three frames back-to-back with frame index f added to re (re=k+f) -> 48 consecutive out_valid cycles with no gaps, data correct per frame.
- Backpressure: out_ready toggles 1,0,0,1 during streaming -> outputs are stable while out_ready=0, no pair is skipped or duplicated, and out_idx stays monotonic.
- Overflow: out_ready=0, three full frames fed -> frames 1 and 2 stored; every pair of frame 3 is dropped and overflow=1. Raising out_ready then drains frames 1 and 2 intact.
- Resync: 5 pairs, then in_start with a full frame -> only the full frame is emitted and it is correct.
- Reset: rst_n low mid-stream (i=7) -> all outputs 0 immediately. After release, a fresh frame streams correctly from i=0.
